// File: rtl/udp_reg_ring_slave_pkg.sv
// Shared constants for user-data-path register ring blocks.
//  - ring address/data widths
//  - value returned for reads of unmapped offsets
//  - per-block address tags
//  - decode region enumeration for in-block offsets
package udp_reg_ring_slave_pkg;

  localparam int unsigned UDP_REG_ADDR_WIDTH  = 23;
  localparam int unsigned CPCI_NF2_DATA_WIDTH = 32;

  localparam logic [31:0] REG_BAD_ADDR = 32'hDEAD_BEEF;

  // Block tags, compared against the upper address bits above the in-block offset.
  localparam int unsigned RING_SLAVE_TAG  = 0;
  localparam int unsigned RING_SLAVE1_TAG = 1;
  localparam int unsigned RING_SLAVE2_TAG = 2;
  localparam int unsigned RING_SLAVE3_TAG = 3;

  typedef enum logic [1:0] {
    REGION_COUNTER,
    REGION_SW_REG,
    REGION_BAD
  } region_e;

endpackage

// File: rtl/udp_reg_counter_bank.sv
// Bank of NUM_COUNTERS event counters with a combinational read mux.
// Ports:
//  clk, reset    core clock, async active-high reset
//  counter_incr  bit i=1 increments counter i this cycle
//  rd_en         a read of the counter selected by rd_sel is being served
//  rd_sel        counter index
//  rd_data       selected counter, zero-extended to 32 bits (pre-update value)
module udp_reg_counter_bank
  import udp_reg_ring_slave_pkg::*;
#(
  parameter int unsigned NUM_COUNTERS  = 4,
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter int unsigned RESET_ON_READ = 0,
  parameter int unsigned SEL_WIDTH     = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_COUNTERS-1:0] counter_incr,
  input  logic                    rd_en,
  input  logic [SEL_WIDTH-1:0]    rd_sel,
  output logic [CPCI_NF2_DATA_WIDTH-1:0] rd_data
);

  logic [COUNTER_WIDTH-1:0] cnt_q [NUM_COUNTERS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_COUNTERS; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
        // Clear-on-read keeps a same-cycle event by restarting at 1.
        if (RESET_ON_READ != 0 && rd_en && rd_sel == SEL_WIDTH'(i))
          cnt_q[i] <= counter_incr[i] ? COUNTER_WIDTH'(1) : '0;
        else if (counter_incr[i])
          cnt_q[i] <= cnt_q[i] + COUNTER_WIDTH'(1);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_COUNTERS; i++)
      if (rd_sel == SEL_WIDTH'(i)) rd_data[COUNTER_WIDTH-1:0] = cnt_q[i];
  end

endmodule

// File: rtl/udp_reg_ring_slave.sv
// Register-ring responder: one-cycle pipelined ring stage that claims requests
// whose address tag equals TAG and serves them from local counters and
// software registers.
// Ports:
//  clk, reset            core clock, async active-high reset
//  reg_*_in / reg_*_out  ring word in, registered ring word out
//  counter_incr          per-counter event strobes
//  sw_regs               software registers, reg j at [32j+31:32j]
module udp_reg_ring_slave
  import udp_reg_ring_slave_pkg::*;
#(
  parameter int unsigned UDP_REG_SRC_WIDTH  = 2,
  parameter int unsigned UDP_REG_ADDR_WIDTH = udp_reg_ring_slave_pkg::UDP_REG_ADDR_WIDTH,
  parameter int unsigned TAG                = RING_SLAVE_TAG,
  parameter int unsigned REG_ADDR_WIDTH     = 5,
  parameter int unsigned NUM_COUNTERS       = 4,
  parameter int unsigned COUNTER_WIDTH      = 32,
  parameter int unsigned NUM_SW_REGS        = 4,
  parameter int unsigned RESET_ON_READ      = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          reg_req_in,
  input  logic                          reg_ack_in,
  input  logic                          reg_rd_wr_L_in,
  input  logic [UDP_REG_ADDR_WIDTH-1:0] reg_addr_in,
  input  logic [31:0]                   reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]  reg_src_in,
  output logic                          reg_req_out,
  output logic                          reg_ack_out,
  output logic                          reg_rd_wr_L_out,
  output logic [UDP_REG_ADDR_WIDTH-1:0] reg_addr_out,
  output logic [31:0]                   reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]  reg_src_out,
  input  logic [NUM_COUNTERS-1:0]       counter_incr,
  output logic [32*NUM_SW_REGS-1:0]     sw_regs
);

  localparam int unsigned TAG_WIDTH = UDP_REG_ADDR_WIDTH - REG_ADDR_WIDTH;

  logic [TAG_WIDTH-1:0]      addr_tag;
  logic [REG_ADDR_WIDTH-1:0] offset;
  logic [31:0]               sw_idx;
  logic                      hit;
  region_e                   region;
  logic [31:0]               cnt_rd_data;
  logic [31:0]               rd_value;
  logic [31:0]               sw_reg_q [NUM_SW_REGS];

  assign addr_tag = reg_addr_in[UDP_REG_ADDR_WIDTH-1:REG_ADDR_WIDTH];
  assign offset   = reg_addr_in[REG_ADDR_WIDTH-1:0];
  assign sw_idx   = 32'(offset) - NUM_COUNTERS;
  assign hit      = reg_req_in & ~reg_ack_in & (addr_tag == TAG_WIDTH'(TAG));

  always_comb begin
    region = REGION_BAD;
    if (32'(offset) < NUM_COUNTERS)                    region = REGION_COUNTER;
    else if (32'(offset) < NUM_COUNTERS + NUM_SW_REGS) region = REGION_SW_REG;
  end

  udp_reg_counter_bank #(
    .NUM_COUNTERS  (NUM_COUNTERS),
    .COUNTER_WIDTH (COUNTER_WIDTH),
    .RESET_ON_READ (RESET_ON_READ),
    .SEL_WIDTH     (REG_ADDR_WIDTH)
  ) u_counter_bank (
    .clk          (clk),
    .reset        (reset),
    .counter_incr (counter_incr),
    .rd_en        (hit & reg_rd_wr_L_in & (region == REGION_COUNTER)),
    .rd_sel       (offset),
    .rd_data      (cnt_rd_data)
  );

  always_comb begin
    rd_value = REG_BAD_ADDR;
    case (region)
      REGION_COUNTER: rd_value = cnt_rd_data;
      REGION_SW_REG: begin
        rd_value = '0;
        for (int unsigned j = 0; j < NUM_SW_REGS; j++)
          if (sw_idx == j) rd_value = sw_reg_q[j];
      end
      default: rd_value = REG_BAD_ADDR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned j = 0; j < NUM_SW_REGS; j++) sw_reg_q[j] <= '0;
    end else if (hit && !reg_rd_wr_L_in && region == REGION_SW_REG) begin
      for (int unsigned j = 0; j < NUM_SW_REGS; j++)
        if (sw_idx == j) sw_reg_q[j] <= reg_data_in;
    end
  end

  always_comb begin
    sw_regs = '0;
    for (int unsigned j = 0; j < NUM_SW_REGS; j++) sw_regs[32*j +: 32] = sw_reg_q[j];
  end

  // Write hits echo the request data, so only read hits replace it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
    end else begin
      reg_req_out     <= reg_req_in;
      reg_ack_out     <= reg_ack_in | hit;
      reg_rd_wr_L_out <= reg_rd_wr_L_in;
      reg_addr_out    <= reg_addr_in;
      reg_data_out    <= (hit && reg_rd_wr_L_in) ? rd_value : reg_data_in;
      reg_src_out     <= reg_src_in;
    end
  end

endmodule
